dcm_multi_phaseshift_ctrl: RTL and testbench

//  Parametrised successor to the single-DCM phase-shift interface. Drives the variable phase-shift port
//  (PSEN/PSINCDEC/PSDONE) of N_CH DCM_SP instances from one shared register interface. Walks each DCM's

---
 rtl/dcm_multi_phaseshift_ctrl_if.sv | 26 ++
 rtl/dcm_multi_phaseshift_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_dcm_multi_phaseshift_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcm_multi_phaseshift_ctrl_if.sv
// Host register-side bundle for the multi-DCM phase-shift controller.
// The host (master) issues load strobes and the controller (slave) reports status and tracked phase.
interface dcm_multi_phaseshift_ctrl_if #(
  parameter int N_CH    = 2,
  parameter int PHASE_W = 9
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [CH_W-1:0]           ch_sel_i;
  logic [PHASE_W-1:0]        value_i;
  logic                      load_i;
  logic                      busy_o;
  logic                      done_o;
  logic [1:0]                err_code_o;
  logic [N_CH*PHASE_W-1:0]   value_o;

  modport master (
    output ch_sel_i, value_i, load_i,
    input  busy_o, done_o, err_code_o, value_o
  );

  modport slave (
    input  ch_sel_i, value_i, load_i,
    output busy_o, done_o, err_code_o, value_o
  );
endinterface

// File: rtl/dcm_multi_phaseshift_ctrl.sv
// Walks the PSEN/PSINCDEC port of N_CH DCMs one unit step at a time toward a clamped signed target.
// First PSEN one cycle after an accepted load; loads while busy (or to a missing channel) are dropped.
module dcm_multi_phaseshift_ctrl #(
  parameter int N_CH      = 2,
  parameter int PHASE_W   = 9,
  parameter int MAX_PHASE = 255,
  parameter int TIMEOUT   = 1023
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  dcm_multi_phaseshift_ctrl_if.slave   host,
  output logic [N_CH-1:0]              dcm_psen_o,
  output logic [N_CH-1:0]              dcm_psincdec_o,
  input  logic [N_CH-1:0]              dcm_psdone_i,
  input  logic [N_CH-1:0]              dcm_ovf_i,
  input  logic [N_CH-1:0]              dcm_locked_i,
  input  logic [N_CH-1:0]              dcm_rst_i
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]           TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic signed [PHASE_W-1:0] MAXP    = PHASE_W'(MAX_PHASE);
  localparam logic signed [PHASE_W-1:0] MINP    = -MAXP;
  localparam logic signed [PHASE_W-1:0] ONE     = PHASE_W'(1);

  typedef enum logic [1:0] {IDLE, STEP, WAIT, FIN} state_t;

  state_t                      state;
  logic [CH_W-1:0]             ch;
  logic signed [PHASE_W-1:0]   target;
  logic signed [PHASE_W-1:0]   phase [N_CH];
  logic [TO_W-1:0]             tmo;
  logic                        busy;
  logic                        done;
  logic [1:0]                  err;

  logic signed [PHASE_W-1:0]   req_val;
  logic signed [PHASE_W-1:0]   req_clamped;
  logic signed [PHASE_W-1:0]   cur_sel;
  logic signed [PHASE_W-1:0]   cur_act;
  logic signed [PHASE_W-1:0]   next_act;
  logic [N_CH-1:0]             sel_oh;
  logic [N_CH-1:0]             act_oh;
  logic                        ch_ok;
  logic                        locked_sel;
  logic                        locked_act;
  logic                        psdone_act;
  logic                        ovf_act;
  logic                        rst_act;
  logic                        up_req;
  logic                        step_ok;

  always_comb begin
    req_val     = $signed(host.value_i);
    req_clamped = req_val;
    if (req_val > MAXP) begin
      req_clamped = MAXP;
    end else if (req_val < MINP) begin
      req_clamped = MINP;
    end
    ch_ok   = int'(host.ch_sel_i) < N_CH;
    sel_oh  = '0;
    act_oh  = '0;
    cur_sel = '0;
    cur_act = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(host.ch_sel_i) == k) begin
        sel_oh[k] = 1'b1;
        cur_sel   = phase[k];
      end
      if (int'(ch) == k) begin
        act_oh[k] = 1'b1;
        cur_act   = phase[k];
      end
    end
    locked_sel = |(dcm_locked_i & sel_oh);
    locked_act = |(dcm_locked_i & act_oh);
    psdone_act = |(dcm_psdone_i & act_oh);
    ovf_act    = |(dcm_ovf_i & act_oh);
    rst_act    = |(dcm_rst_i & act_oh);
    up_req     = req_clamped > cur_sel;
    // Saturating unit step; the tracked phase never wraps past +/-MAX_PHASE.
    if (target > cur_act) begin
      next_act = (cur_act >= MAXP) ? MAXP : cur_act + ONE;
    end else begin
      next_act = (cur_act <= MINP) ? MINP : cur_act - ONE;
    end
    step_ok = (state == WAIT) && psdone_act && !ovf_act && !rst_act && locked_act;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= IDLE;
      ch             <= '0;
      target         <= '0;
      tmo            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 2'd0;
      dcm_psen_o     <= '0;
      dcm_psincdec_o <= '0;
      for (int k = 0; k < N_CH; k++) begin
        phase[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (host.load_i && ch_ok) begin
            ch     <= host.ch_sel_i;
            target <= req_clamped;
            busy   <= 1'b1;
            err    <= 2'd0;
            if (!locked_sel) begin
              err   <= 2'd3;
              state <= FIN;
            end else if (req_clamped == cur_sel) begin
              state <= FIN;
            end else begin
              state          <= STEP;
              dcm_psen_o     <= sel_oh;
              dcm_psincdec_o <= up_req ? sel_oh : '0;
            end
          end
        end
        STEP: begin
          dcm_psen_o <= '0;
          tmo        <= '0;
          if (rst_act || !locked_act) begin
            err            <= 2'd3;
            dcm_psincdec_o <= '0;
            state          <= FIN;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          tmo <= tmo + 1'b1;
          if (rst_act || !locked_act) begin
            err            <= 2'd3;
            dcm_psincdec_o <= '0;
            state          <= FIN;
          end else if (psdone_act) begin
            if (ovf_act) begin
              err            <= 2'd2;
              dcm_psincdec_o <= '0;
              state          <= FIN;
            end else if (next_act == target) begin
              dcm_psincdec_o <= '0;
              state          <= FIN;
            end else begin
              state          <= STEP;
              dcm_psen_o     <= act_oh;
              dcm_psincdec_o <= (target > next_act) ? act_oh : '0;
            end
          end else if (tmo == TO_LAST) begin
            err            <= 2'd1;
            dcm_psincdec_o <= '0;
            state          <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (rst_act) begin
            err <= 2'd3;
          end
        end
        default: state <= IDLE;
      endcase
      // A DCM reset wins over a same-cycle PSDONE update on that channel.
      for (int k = 0; k < N_CH; k++) begin
        if (dcm_rst_i[k]) begin
          phase[k] <= '0;
        end else if (step_ok && act_oh[k]) begin
          phase[k] <= next_act;
        end
      end
    end
  end

  assign host.busy_o     = busy;
  assign host.done_o     = done;
  assign host.err_code_o = err;

  for (genvar g = 0; g < N_CH; g++) begin : g_val
    assign host.value_o[g*PHASE_W +: PHASE_W] = phase[g];
  end
endmodule

// File: tb/tb_dcm_multi_phaseshift_ctrl.sv
// Randomised bench for the multi-DCM phase-shift controller with a DCM responder and an arithmetic phase model.
module tb_dcm_multi_phaseshift_ctrl;
  localparam int NC = 3;
  localparam int PW = 10;
  localparam int MP = 255;
  localparam int TO = 40;

  logic          clk;
  logic          reset_n;
  logic [NC-1:0] psen;
  logic [NC-1:0] psincdec;
  logic [NC-1:0] psdone;
  logic [NC-1:0] ovf;
  logic [NC-1:0] locked;
  logic [NC-1:0] dcm_rst;

  int n_chk  = 0;
  int n_pass = 0;

  // DCM responder / monitor state
  int psen_cnt [NC];
  int inc_cnt  [NC];
  int pd_total [NC];
  int pend     [NC];
  int ovf_at   [NC];
  int done_cnt = 0;
  bit withhold = 0;
  bit rand_dly = 0;

  // Reference model of tracked phase per channel
  int mph [NC];

  dcm_multi_phaseshift_ctrl_if #(.N_CH(NC), .PHASE_W(PW)) bus ();

  dcm_multi_phaseshift_ctrl #(
    .N_CH(NC), .PHASE_W(PW), .MAX_PHASE(MP), .TIMEOUT(TO)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .host           (bus),
    .dcm_psen_o     (psen),
    .dcm_psincdec_o (psincdec),
    .dcm_psdone_i   (psdone),
    .dcm_ovf_i      (ovf),
    .dcm_locked_i   (locked),
    .dcm_rst_i      (dcm_rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int k = 0; k < NC; k++) begin
      psen_cnt[k] = 0; inc_cnt[k] = 0; pd_total[k] = 0; pend[k] = 0; ovf_at[k] = -1;
    end
  end

  always @(negedge clk) begin
    psdone = '0;
    ovf    = '0;
    if (bus.done_o) done_cnt++;
    for (int k = 0; k < NC; k++) begin
      if (psen[k]) begin
        psen_cnt[k]++;
        if (psincdec[k]) inc_cnt[k]++;
        pend[k] = withhold ? 0 : (rand_dly ? int'($urandom_range(1, 4)) : 2);
      end else if (pend[k] > 0) begin
        pend[k]--;
        if (pend[k] == 0) begin
          psdone[k] = 1'b1;
          pd_total[k]++;
          if (pd_total[k] == ovf_at[k]) ovf[k] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int clamp(input int v);
    return (v > MP) ? MP : ((v < -MP) ? -MP : v);
  endfunction

  function automatic logic signed [63:0] dv(input int k);
    logic signed [PW-1:0] t;
    t = bus.value_o[k*PW +: PW];
    return t;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(inout int lat, output bit ok);
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (bus.done_o) begin
        ok = 1;
        break;
      end
      tick();
      lat++;
    end
  endtask

  task automatic do_load(input int c, input int v, output int lat, output bit ok, output logic [NC-1:0] p1);
    tick();
    bus.ch_sel_i = 2'(c);
    bus.value_i  = PW'(v);
    bus.load_i   = 1'b1;
    tick();
    bus.load_i = 1'b0;
    p1  = psen;
    lat = 1;
    wait_done(lat, ok);
  endtask

  task automatic walk(input string tag, input int c, input int v);
    int tgt, steps, lat, s_inc, s_done;
    int s_ps [NC];
    bit up, ok;
    logic [NC-1:0] p1;
    logic [NC-1:0] one_hot;
    tgt   = clamp(v);
    steps = (tgt > mph[c]) ? tgt - mph[c] : mph[c] - tgt;
    up    = tgt > mph[c];
    one_hot = '0;
    one_hot[c] = 1'b1;
    for (int k = 0; k < NC; k++) s_ps[k] = psen_cnt[k];
    s_inc  = inc_cnt[c];
    s_done = done_cnt;
    do_load(c, v, lat, ok, p1);
    chk({tag, "_done_seen"}, ok, 1);
    chk({tag, "_first_psen"}, p1, (steps != 0) ? one_hot : '0);
    chk({tag, "_err"}, bus.err_code_o, 0);
    chk({tag, "_value"}, dv(c), tgt);
    for (int k = 0; k < NC; k++) chk({tag, "_psen_count"}, psen_cnt[k] - s_ps[k], (k == c) ? steps : 0);
    chk({tag, "_inc_count"}, inc_cnt[c] - s_inc, up ? steps : 0);
    if (steps == 0) chk({tag, "_zero_lat"}, lat, 2);
    tick();
    chk({tag, "_single_done"}, done_cnt - s_done, 1);
    chk({tag, "_idle"}, bus.busy_o, 0);
    mph[c] = tgt;
  endtask

  initial begin
    int lat, v, s0, s1, s_done, s_all;
    bit ok;
    logic [NC-1:0] p1;
    for (int k = 0; k < NC; k++) mph[k] = 0;
    reset_n = 1'b0;
    bus.ch_sel_i = '0; bus.value_i = '0; bus.load_i = 1'b0;
    locked = '1; dcm_rst = '0;
    repeat (3) tick();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_err", bus.err_code_o, 0);
    chk("rst_value", bus.value_o, 0);
    chk("rst_psen", psen, 0);
    chk("rst_psincdec", psincdec, 0);
    reset_n = 1'b1;
    tick();

    // Fixed two-cycle PSDONE response
    walk("ch0_p3", 0, 3);
    rand_dly = 1;
    walk("ch1_p3", 1, 3);
    walk("ch1_m2", 1, -2);
    chk("ch0_untouched", dv(0), 3);
    walk("clamp_hi", 2, 400);
    walk("clamp_same", 2, 255);

    for (int i = 0; i < 6; i++) begin
      walk("rnd", int'($urandom_range(0, NC - 1)), int'($urandom_range(0, 600)) - 300);
    end
    walk("clamp_lo", 1, -300);

    // Timeout: PSDONE withheld, value keeps last confirmed step
    withhold = 1;
    v  = (mph[0] > 0) ? mph[0] - 5 : mph[0] + 5;
    s0 = psen_cnt[0];
    do_load(0, v, lat, ok, p1);
    chk("to_done_seen", ok, 1);
    chk("to_latency_window", (lat >= TO + 1 && lat <= TO + 4), 1);
    chk("to_err", bus.err_code_o, 1);
    chk("to_value_held", dv(0), mph[0]);
    chk("to_one_psen", psen_cnt[0] - s0, 1);
    repeat (3) tick();
    chk("to_err_persists", bus.err_code_o, 1);
    withhold = 0;

    // Overflow flagged together with the second PSDONE
    v  = (mph[1] > 0) ? mph[1] - 5 : mph[1] + 5;
    ovf_at[1] = pd_total[1] + 2;
    s1 = psen_cnt[1];
    do_load(1, v, lat, ok, p1);
    chk("ovf_done_seen", ok, 1);
    chk("ovf_err", bus.err_code_o, 2);
    chk("ovf_value", dv(1), (v > mph[1]) ? mph[1] + 1 : mph[1] - 1);
    chk("ovf_psens", psen_cnt[1] - s1, 2);
    mph[1] = (v > mph[1]) ? mph[1] + 1 : mph[1] - 1;
    repeat (8) tick();

    // DCM reset on the active channel mid-walk
    v  = (mph[0] > 0) ? mph[0] - 20 : mph[0] + 20;
    s0 = psen_cnt[0];
    tick();
    bus.ch_sel_i = 2'd0; bus.value_i = PW'(v); bus.load_i = 1'b1;
    tick();
    bus.load_i = 1'b0;
    for (int i = 0; i < 500 && (psen_cnt[0] - s0) < 3; i++) tick();
    chk("drst_reached_step3", psen_cnt[0] - s0, 3);
    dcm_rst = 3'b001;
    tick();
    dcm_rst = '0;
    lat = 0;
    wait_done(lat, ok);
    chk("drst_done_seen", ok, 1);
    chk("drst_err", bus.err_code_o, 3);
    chk("drst_value_zero", dv(0), 0);
    mph[0] = 0;
    repeat (8) tick();

    // DCM reset on an idle channel
    dcm_rst = 3'b100;
    tick();
    dcm_rst = '0;
    chk("drst_idle_ch2", dv(2), 0);
    mph[2] = 0;

    // Unlocked DCM: immediate fault, no PSEN
    locked = 3'b110;
    s0 = psen_cnt[0];
    do_load(0, 9, lat, ok, p1);
    chk("unlk_latency", lat, 2);
    chk("unlk_err", bus.err_code_o, 3);
    chk("unlk_no_psen", psen_cnt[0] - s0, 0);
    chk("unlk_value", dv(0), mph[0]);
    locked = '1;

    // Load while busy is dropped
    s1 = psen_cnt[1];
    s_done = done_cnt;
    tick();
    bus.ch_sel_i = 2'd0; bus.value_i = PW'(mph[0] + 4); bus.load_i = 1'b1;
    tick();
    bus.load_i = 1'b0;
    tick();
    bus.ch_sel_i = 2'd1; bus.value_i = PW'(77); bus.load_i = 1'b1;
    tick();
    bus.load_i = 1'b0;
    lat = 0;
    wait_done(lat, ok);
    tick();
    chk("busy_ld_done", ok, 1);
    chk("busy_ld_ch0", dv(0), mph[0] + 4);
    chk("busy_ld_ch1_kept", dv(1), mph[1]);
    chk("busy_ld_ch1_no_psen", psen_cnt[1] - s1, 0);
    chk("busy_ld_one_done", done_cnt - s_done, 1);
    mph[0] = mph[0] + 4;

    // Channel index beyond N_CH is ignored
    s_all  = psen_cnt[0] + psen_cnt[1] + psen_cnt[2];
    s_done = done_cnt;
    tick();
    bus.ch_sel_i = 2'd3; bus.value_i = PW'(9); bus.load_i = 1'b1;
    tick();
    bus.load_i = 1'b0;
    chk("badch_not_busy", bus.busy_o, 0);
    repeat (5) tick();
    chk("badch_no_done", done_cnt - s_done, 0);
    chk("badch_no_psen", psen_cnt[0] + psen_cnt[1] + psen_cnt[2] - s_all, 0);
    chk("badch_ch2", dv(2), mph[2]);

    // Asynchronous reset in the middle of a WAIT
    withhold = 1;
    tick();
    bus.ch_sel_i = 2'd1; bus.value_i = PW'(mph[1] + 10); bus.load_i = 1'b1;
    tick();
    bus.load_i = 1'b0;
    repeat (4) tick();
    chk("arst_pre_busy", bus.busy_o, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy_o, 0);
    chk("arst_value", bus.value_o, 0);
    chk("arst_psen", psen, 0);
    chk("arst_err", bus.err_code_o, 0);
    tick();
    reset_n = 1'b1;
    withhold = 0;
    for (int k = 0; k < NC; k++) mph[k] = 0;
    tick();
    walk("post_rst", 2, -7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
